// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver: lamp test after reset, then scans tens/ones
// from a per-frame latched value, with leading-zero blanking, dash overflow and zero flash.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 131072,
    parameter int unsigned BLANK_CYC   = 1024,
    parameter int unsigned LAMP_CYC    = 25000000,
    parameter int unsigned FLASH_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] value,
    input  logic       flash_en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame
);

    localparam int unsigned CNT_MAX = (LAMP_CYC > REFRESH_DIV) ? LAMP_CYC : REFRESH_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FL_W    = $clog2(FLASH_DIV + 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_TENS  = 4'b0111;
    localparam logic [3:0] AN_ONES  = 4'b1011;

    typedef enum logic [1:0] {LAMP, TENS, ONES} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        val_q, val_d;
    logic [FL_W-1:0]   fcnt_q, fcnt_d;
    logic              fdark_q, fdark_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic              frame_q, frame_d;

    logic [3:0]        tens;
    logic [3:0]        ones;
    logic              flash_act;
    logic              last_slot;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = SEG_OFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LAMP;
            cnt_q   <= '0;
            val_q   <= '0;
            fcnt_q  <= '0;
            fdark_q <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            fcnt_q  <= fcnt_d;
            fdark_q <= fdark_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    // Binary to two BCD digits by compare-subtract; only meaningful for 0..99.
    always_comb begin
        tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (val_q >= 7'(10 * i)) tens = 4'(i);
        end
        ones = 4'(val_q - 7'(tens) * 7'd10);
    end

    assign last_slot = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign flash_act = (state_q != LAMP) && (val_q == 7'd0) && flash_en;

    // Next state, value latch and flash phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        fcnt_d  = '0;
        fdark_d = 1'b0;
        case (state_q)
            LAMP: if (cnt_q == CNT_W'(LAMP_CYC - 1)) begin
                state_d = TENS;
                cnt_d   = '0;
            end
            TENS: if (last_slot) begin
                state_d = ONES;
                cnt_d   = '0;
            end
            ONES: if (last_slot) begin
                state_d = TENS;
                cnt_d   = '0;
            end
            default: begin
                state_d = LAMP;
                cnt_d   = '0;
            end
        endcase
        val_d = (state_d == TENS && state_q != TENS) ? value : val_q;
        if (flash_act) begin
            if (fcnt_q == FL_W'(FLASH_DIV - 1)) begin
                fcnt_d  = '0;
                fdark_d = ~fdark_q;
            end else begin
                fcnt_d  = fcnt_q + FL_W'(1);
                fdark_d = fdark_q;
            end
        end
    end

    // Output image for the current slot position, registered on the next edge.
    always_comb begin
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        frame_d = (state_q == TENS) && (cnt_q == '0);
        if (state_q == LAMP) begin
            an_d  = 4'b0000;
            seg_d = 7'b0000000;
        end else if (cnt_q >= CNT_W'(BLANK_CYC) && !(flash_act && fdark_q)) begin
            if (val_q > 7'd99) begin
                an_d  = (state_q == TENS) ? AN_TENS : AN_ONES;
                seg_d = SEG_DASH;
            end else if (state_q == ONES) begin
                an_d  = AN_ONES;
                seg_d = dec7(ones);
            end else if (tens != 4'd0) begin
                an_d  = AN_TENS;
                seg_d = dec7(tens);
            end
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: reset-release vector table, directed corner sequences and a
// randomized run against a frame/slot arithmetic model of the display.
module tb_seg_scan_driver;

    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;
    localparam int unsigned LC = 4;
    localparam int unsigned FD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] value;
    logic       flash_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC),
        .LAMP_CYC   (LC),
        .FLASH_DIV  (FD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .value   (value),
        .flash_en(flash_en),
        .seg     (seg),
        .an      (an),
        .frame   (frame)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state: k = output edges since reset release, lat = value shown this frame,
    // run = consecutive edges the zero-flash condition has held.
    int k = 0;
    int lat = 0;
    int run = 0;

    typedef struct {
        logic       rst;
        logic [6:0] val;
        logic       fen;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fr;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [6:0] digit(input int d);
        logic [6:0] pat[10];
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return pat[d];
    endfunction

    task automatic model_step(input logic rst, input int val, input logic fen,
                              output logic [3:0] ean, output logic [6:0] eseg, output logic efr);
        int pos, slot, sc;
        bit cond, lit;
        ean  = 4'b1111;
        eseg = 7'b1111111;
        efr  = 1'b0;
        if (rst) begin
            k = 0; lat = 0; run = 0;
            return;
        end
        k++;
        if (k <= LC) begin
            ean = 4'b0000; eseg = 7'b0000000; run = 0;
        end else begin
            pos  = (k - LC - 1) % (2 * RD);
            slot = pos / RD;
            sc   = pos % RD;
            efr  = (pos == 0);
            cond = (lat == 0) && fen;
            lit  = !cond || ((run / FD) % 2 == 0);
            run  = cond ? run + 1 : 0;
            if (sc >= BC && lit) begin
                if (lat > 99) begin
                    ean = slot ? 4'b1011 : 4'b0111; eseg = 7'b0111111;
                end else if (slot == 1) begin
                    ean = 4'b1011; eseg = digit(lat % 10);
                end else if (lat / 10 != 0) begin
                    ean = 4'b0111; eseg = digit(lat / 10);
                end
            end
        end
        if (k >= LC && (k - LC) % (2 * RD) == 0) lat = val;
    endtask

    task automatic compare(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                           input logic efr);
        vectors++;
        if (an !== ean || seg !== eseg || frame !== efr) begin
            miscompares++;
            $display("FAIL %s k=%0d: got an=%b seg=%b frame=%b, expected an=%b seg=%b frame=%b",
                     tag, k, an, seg, frame, ean, eseg, efr);
        end
    endtask

    task automatic step(input logic rst, input int val, input logic fen, input string tag);
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       efr;
        reset = rst; value = 7'(val); flash_en = fen;
        model_step(rst, val, fen, ean, eseg, efr);
        @(posedge clk); #1;
        compare(tag, ean, eseg, efr);
    endtask

    function automatic int next_pos();
        return (k - LC) % (2 * RD);
    endfunction

    initial begin
        logic [3:0] dan;
        logic [6:0] dseg;
        logic       dfr;
        int v;
        logic f;

        reset = 1'b1; value = 7'd42; flash_en = 1'b0;
        @(posedge clk); #1;

        // Reset release with value 42: expected image written out cycle by cycle.
        tbl[0] = '{1'b1, 7'd42, 1'b0, 4'b1111, 7'b1111111, 1'b0};
        for (int i = 1; i <= 20; i++) begin
            tbl[i] = '{1'b0, 7'd42, 1'b0, 4'b1111, 7'b1111111, 1'b0};
            if (i <= 4)                tbl[i].an = 4'b0000;
            if (i <= 4)                tbl[i].seg = 7'b0000000;
            if (i == 5)                tbl[i].fr = 1'b1;
            if (i >= 7 && i <= 12)     begin tbl[i].an = 4'b0111; tbl[i].seg = 7'b0011001; end
            if (i >= 15)               begin tbl[i].an = 4'b1011; tbl[i].seg = 7'b0100100; end
        end
        foreach (tbl[i]) begin
            reset = tbl[i].rst; value = tbl[i].val; flash_en = tbl[i].fen;
            model_step(tbl[i].rst, int'(tbl[i].val), tbl[i].fen, dan, dseg, dfr);
            @(posedge clk); #1;
            compare($sformatf("table[%0d]", i), tbl[i].an, tbl[i].seg, tbl[i].fr);
        end

        // Single digit with blanked leading zero, then overflow dashes.
        repeat (4 * RD) step(1'b0, 7, 1'b0, "value7");
        repeat (4 * RD) step(1'b0, 115, 1'b0, "value115");

        // Value changed mid-ONES slot must not disturb the frame on display.
        repeat (4 * RD) step(1'b0, 42, 1'b0, "hold42");
        while (next_pos() != RD + 4) step(1'b0, 42, 1'b0, "hold42");
        repeat (6 * RD) step(1'b0, 13, 1'b0, "change13");

        // Zero flash over several on/off intervals, then steady zero.
        repeat (12 * RD) step(1'b0, 0, 1'b1, "flash0");
        repeat (4 * RD) step(1'b0, 0, 1'b0, "steady0");
        repeat (6 * RD) step(1'b0, 0, 1'b1, "reflash0");

        // Reset in the middle of a TENS slot restarts the lamp test.
        while (next_pos() != 4) step(1'b0, 88, 1'b0, "pre_rst");
        step(1'b1, 88, 1'b0, "mid_rst");
        repeat (LC + 4 * RD) step(1'b0, 88, 1'b0, "post_rst");

        // Randomized run, values biased towards boundaries and zero.
        v = 0; f = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 7))
                    0, 1:    v = 0;
                    2:       v = 9;
                    3:       v = 10;
                    4:       v = 99;
                    5:       v = 100;
                    6:       v = 127;
                    default: v = $urandom_range(0, 127);
                endcase
            end
            if ($urandom_range(0, 99) == 0) f = ~f;
            step(($urandom_range(0, 599) == 0), v, f, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
